// File: rtl/serial_addsub_if.sv
// Operand/result bundle for serial_addsub: start/busy/done handshake plus data and flags.
// The master drives the request; the slave (the adder) drives status and results.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Serial add/subtract unit. Operands are consumed LSB-first, BITS_PER_CYCLE bits per clock.
// Carry or borrow ripples through one slice per clock and is held in a register between slices.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one slice processed per clock, N clocks total
// DONE  | one-cycle done pulse; start here chains straight into RUN
module serial_addsub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);
  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = WIDTH / BPC;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [BPC-1:0]   slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;
  logic [WIDTH-1:0] acc_next;
  logic             accept;

  // Ripple of one-bit cells; the same chain serves as carry (add) or borrow (subtract).
  always_comb begin : slice_chain
    logic [BPC:0] ch;
    ch        = '0;
    ch[0]     = carry_q;
    slice_sum = '0;
    for (int i = 0; i < BPC; i++) begin
      slice_sum[i] = a_q[i] ^ b_q[i] ^ ch[i];
      if (mode_q) ch[i+1] = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & ch[i]);
      else        ch[i+1] = (a_q[i] & b_q[i]) | (ch[i] & (a_q[i] ^ b_q[i]));
    end
    slice_cout = ch[BPC];
    slice_cmsb = ch[BPC-1];
  end

  // New slice enters at the top so the word is aligned after N shifts.
  assign acc_next = (acc_q >> BPC) | (WIDTH'(slice_sum) << (WIDTH - BPC));
  assign accept   = bus.start && (state_q != RUN);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: state_d = bus.start ? RUN : IDLE;
      RUN: begin
        a_d     = a_q >> BPC;
        b_d     = b_q >> BPC;
        carry_d = slice_cout;
        acc_d   = acc_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = acc_next;
          cout_d   = slice_cout;
          ovf_d    = slice_cmsb ^ slice_cout;
        end
      end
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      mode_d  = bus.mode;
      carry_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      mode_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: one instance slicing 1 bit/clock, one slicing 4 bits/clock.
// Vector table covers arithmetic; hand sequences cover handshake and reset corners.
module tb_serial_addsub;
  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start4, mode;
  logic [7:0] a, b;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) if1 ();
  serial_addsub_if #(.WIDTH(8)) if4 ();

  assign if1.start = start1;
  assign if1.mode  = mode;
  assign if1.a     = a;
  assign if1.b     = b;
  assign if4.start = start4;
  assign if4.mode  = mode;
  assign if4.a     = a;
  assign if4.b     = b;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_bpc1 (.clk(clk), .rst(rst), .bus(if1));
  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_bpc4 (.clk(clk), .rst(rst), .bus(if4));

  typedef struct {
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[9];

  function automatic logic get_busy(int sel);
    return (sel == 1) ? if1.busy : if4.busy;
  endfunction
  function automatic logic get_done(int sel);
    return (sel == 1) ? if1.done : if4.done;
  endfunction
  function automatic logic [7:0] get_res(int sel);
    return (sel == 1) ? if1.result : if4.result;
  endfunction
  function automatic logic get_cout(int sel);
    return (sel == 1) ? if1.cout : if4.cout;
  endfunction
  function automatic logic get_ovf(int sel);
    return (sel == 1) ? if1.overflow : if4.overflow;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the edge that samples start.
  task automatic pulse_start(input int sel, input logic m, input logic [7:0] aa, input logic [7:0] bb);
    mode = m;
    a    = aa;
    b    = bb;
    if (sel == 1) start1 = 1'b1;
    else          start4 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    a      = 8'hA5;
    b      = 8'h5A;
  endtask

  task automatic wait_done(input int sel, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!get_done(sel) && lat < 20) begin
      if (get_busy(sel)) bc++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic chk_outs(input string tag, input int sel, input logic [7:0] r, input logic c, input logic o);
    chk({tag, ".result"}, 32'(get_res(sel)), 32'(r));
    chk({tag, ".cout"}, 32'(get_cout(sel)), 32'(c));
    chk({tag, ".overflow"}, 32'(get_ovf(sel)), 32'(o));
  endtask

  initial begin
    int lat, bc, n;
    vecs[0] = '{1'b1, 8'h35, 8'h12, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 8'h3C, 8'h45, 8'h81, 1'b0, 1'b1};

    rst = 1'b1; start1 = 1'b0; start4 = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 1; s <= 4; s += 3) begin
      chk($sformatf("reset.bpc%0d.busy", s), 32'(get_busy(s)), 32'd0);
      chk($sformatf("reset.bpc%0d.done", s), 32'(get_done(s)), 32'd0);
      chk_outs($sformatf("reset.bpc%0d", s), s, 8'h00, 1'b0, 1'b0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int s = 1; s <= 4; s += 3) begin
      n = 8 / s;
      for (int i = 0; i < 9; i++) begin
        pulse_start(s, vecs[i].mode, vecs[i].a, vecs[i].b);
        wait_done(s, lat, bc);
        chk($sformatf("vec%0d.bpc%0d.latency", i, s), 32'(lat), 32'(n));
        chk($sformatf("vec%0d.bpc%0d.busy_cycles", i, s), 32'(bc), 32'(n));
        chk_outs($sformatf("vec%0d.bpc%0d", i, s), s, vecs[i].res, vecs[i].co, vecs[i].ov);
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d.bpc%0d.done_one_cycle", i, s), 32'(get_done(s)), 32'd0);
        chk($sformatf("vec%0d.bpc%0d.idle_busy", i, s), 32'(get_busy(s)), 32'd0);
      end
    end

    // start during RUN with different operands must be ignored
    pulse_start(1, 1'b1, 8'h35, 8'h12);
    repeat (2) begin @(posedge clk); #1; end
    pulse_start(1, 1'b0, 8'hFF, 8'h01);
    wait_done(1, lat, bc);
    chk("ignore.latency", 32'(lat), 32'd5);
    chk_outs("ignore", 1, 8'h23, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // start held in DONE chains with no idle gap; outputs hold during RUN
    pulse_start(1, 1'b0, 8'h7F, 8'h01);
    wait_done(1, lat, bc);
    chk_outs("b2b.first", 1, 8'h80, 1'b0, 1'b1);
    pulse_start(1, 1'b1, 8'h12, 8'h35);
    chk("b2b.busy_immediate", 32'(get_busy(1)), 32'd1);
    chk("b2b.done_low", 32'(get_done(1)), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk_outs("b2b.hold", 1, 8'h80, 1'b0, 1'b1);
    wait_done(1, lat, bc);
    chk("b2b.latency", 32'(lat), 32'd5);
    chk_outs("b2b.second", 1, 8'hDD, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    // reset while slice 3 is due
    pulse_start(1, 1'b1, 8'h35, 8'h12);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstmid.busy", 32'(get_busy(1)), 32'd0);
    chk("rstmid.done", 32'(get_done(1)), 32'd0);
    chk_outs("rstmid", 1, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("rstmid.no_done", 32'(get_done(1)), 32'd0);
    chk("rstmid.idle", 32'(get_busy(1)), 32'd0);
    pulse_start(1, 1'b1, 8'h80, 8'h01);
    wait_done(1, lat, bc);
    chk("rstmid.fresh_latency", 32'(lat), 32'd8);
    chk_outs("rstmid.fresh", 1, 8'h7F, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
